// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder (LSB first, one fulladder); SERIAL_ADDER_OVF_EN adds the signed ovf output.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and a start held high is taken in the next IDLE cycle.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] sum_sh;
  logic [CW-1:0]    count;
  logic             carry;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;

  fulladder u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // The partial sum only needs WIDTH-1 bits; the last sum bit lands straight in sum.
  assign sum_next = {fa_s, sum_sh};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_sh <= '0;
      count  <= '0;
      carry  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= cin_in;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sum_sh <= sum_next[WIDTH-1:1];
          carry  <= fa_cout;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            sum   <= sum_next;
            cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry here is the carry into the MSB position
            ovf   <= carry ^ fa_cout;
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// One-bit full adder used by the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  res_t last = '0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .cin_in (cin_in),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .cout   (cout),
    .ovf    (ovf)
`else
    .cout   (cout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    longint t;
    res_t   r;
    t      = longint'(a) + longint'(b) + longint'(c);
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Present operands and pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
  endtask

  // Waits (bounded) for done, counting cycles since the accepting edge and busy cycles.
  task automatic wait_done(input string tag, input int lat0, output int lat, output int bz);
    int unstable;
    unstable = 0;
    lat = lat0;
    bz  = lat0 - 1;
    while (!done && lat <= 4 * WIDTH) begin
      if (busy) bz++;
      if (sum !== last.sum || cout !== last.cout) unstable++;
      @(negedge clk);
      lat++;
    end
    if (busy) bz++;
    check({tag, ":latency"}, 64'(lat), 64'(WIDTH + 1));
    check({tag, ":held"}, 64'(unstable), 64'd0);
  endtask

  task automatic check_result(input string tag, input res_t e);
    check({tag, ":sum"}, 64'(sum), 64'(e.sum));
    check({tag, ":cout"}, 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ":ovf"}, 64'(ovf), 64'(e.ovf));
`endif
    last = e;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        input string tag);
    res_t e;
    int   lat, bz;
    e = model(a, b, c);
    issue(a, b, c);
    wait_done(tag, 1, lat, bz);
    check({tag, ":busy_cycles"}, 64'(bz), 64'(WIDTH + 1));
    check_result(tag, e);
    @(negedge clk);
    check({tag, ":done_pulse"}, 64'(done), 64'd0);
    check({tag, ":idle"}, 64'(busy), 64'd0);
    check({tag, ":sum_kept"}, 64'(sum), 64'(e.sum));
  endtask

  initial begin
    int   lat, bz, extra;
    res_t e;

    reset = 1'b1; start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:done", 64'(done), 64'd0);
    check("reset:sum", 64'(sum), 64'd0);
    check("reset:cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset:ovf", 64'(ovf), 64'd0);
`endif

    // First edge with reset low must already accept start.
    reset = 1'b0;
    run_op(8'h0F, 8'h01, 1'b0, "d0f01");
    run_op(8'hFF, 8'h01, 1'b0, "dff01");
    run_op(8'h7F, 8'h01, 1'b0, "d7f01");
    run_op(8'h00, 8'h00, 1'b0, "dzero");
    run_op(8'h80, 8'h80, 1'b0, "d8080");

    // Second start three cycles after the first must be ignored.
    e = model(8'hFF, 8'hFF, 1'b1);
    issue(8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 4, lat, bz);
    check("ignore:busy_cycles", 64'(bz), 64'(WIDTH + 1));
    check_result("ignore", e);
    extra = 0;
    repeat (3 * WIDTH) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("ignore:no_second_op", 64'(extra), 64'd0);
    check("ignore:sum_kept", 64'(sum), 64'(e.sum));

    // Start held high through DONE is accepted in the following IDLE cycle.
    e = model(8'h21, 8'h43, 1'b0);
    a_in = 8'h21; b_in = 8'h43; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
    wait_done("hold1", 1, lat, bz);
    check_result("hold1", e);
    e = model(8'hC3, 8'h5A, 1'b1);
    a_in = 8'hC3; b_in = 8'h5A; cin_in = 1'b1;
    @(negedge clk);
    check("hold:idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("hold:reaccepted", 64'(busy), 64'd1);
    wait_done("hold2", 1, lat, bz);
    check_result("hold2", e);
    @(negedge clk);

    // Reset four cycles into SHIFT aborts without a done pulse.
    issue(8'h99, 8'h77, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:sum", 64'(sum), 64'd0);
    check("abort:cout", 64'(cout), 64'd0);
    extra = 0;
    repeat (2 * WIDTH) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    check("abort:no_done", 64'(extra), 64'd0);
    last = '0;
    run_op(8'h12, 8'h34, 1'b0, "after_abort");

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
